dcache_wr_sched: RTL and testbench
==================================

Name: dcache_wr_sched

Overview:
- Write-queue scheduler between the dcache and the AXI bridge's data-side cache port.
- Buffers up to DEPTH dcache write requests (line writebacks and uncached stores) and issues them in FIFO order to the bridge's single-entry write path.
- Lets data reads bypass queued writes, except when a read hits a queued line or is uncached.
- Reads remain combinational pass-through; writes are queued and sequenced by an FSM.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_wr_req  in  1  dcache write request
- in_wr_type  in  3  3'b100 = 16B line, otherwise AXI size of an uncached store
- in_wr_addr  in  32  write address
- in_wr_wstrb  in  4  byte strobes
- in_wr_data  in  128  write data
- in_wr_rdy  out  1  queue can accept
- in_rd_req  in  1  dcache read request
- in_rd_type  in  3  read type
- in_rd_addr  in  32  read address
- in_rd_rdy  out  1  read accepted
- data_wr_req  out  1  to bridge
- data_wr_type  out  3  to bridge
- data_wr_addr  out  32  to bridge
- data_wr_wstrb  out  4  to bridge
- data_wr_data  out  128  to bridge
- data_wr_rdy  in  1  bridge write path idle
- data_rd_req  out  1  to bridge
- data_rd_type  out  3  to bridge
- data_rd_addr  out  32  to bridge
- data_rd_rdy  in  1  bridge accepts read
- write_buffer_empty  in  1  bridge has no write outstanding
- sched_empty  out  1  queue empty, FSM IDLE, and bridge write_buffer_empty

Behaviour:
- Reset (async, resetn low): head/tail/count = 0, FSM = IDLE, data_wr_req = 0, all data_wr_* fields = 0. Combinational outputs are undefined until resetn rises.
- Push: when in_wr_req && in_wr_rdy, store {type, addr, wstrb, data} at tail; tail++ (wraps mod DEPTH); count++.
- in_wr_rdy = (count != DEPTH). It is not relieved by a same-cycle pop.
- FSM IDLE: if count != 0 && data_wr_rdy, go to ISSUE next cycle and register the head entry onto data_wr_*, with data_wr_req = 1.
- FSM ISSUE: data_wr_req is held high with stable fields. On data_wr_req && data_wr_rdy: pop the head (head++, count--), drop data_wr_req, go to GAP.
- FSM GAP: one cycle with data_wr_req = 0, then IDLE. This covers the bridge's rdy-deassert latency.
- Minimum spacing between successive bridge issues: 3 cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Line hazard: hit = in_rd_req and in_rd_addr[31:4] equals addr[31:4] of any valid entry, including the head while in ISSUE, or of the write being pushed this cycle.
- Uncached hold: in_rd_type != 3'b100 && !sched_empty.
- Read gating: block = hit || uncached hold.
  - data_rd_req = in_rd_req && !block.
  - in_rd_rdy = data_rd_rdy && !block.
  - data_rd_type and data_rd_addr pass through unchanged.
  - While blocked, the bridge is free to serve instruction reads.
- Ordering against the bridge: once a write is handed to the bridge, the bridge itself orders later reads, so handed-off entries are excluded from the hazard compare.
- sched_empty = (count == 0) && (FSM == IDLE) && write_buffer_empty.

Optional Feature:
- Macro: WRQ_MERGE_EN.
- Defined: an incoming write with type 3'b100 is merged when a valid non-head entry (or head while the FSM is IDLE) has type 3'b100 and the same addr[31:4].
  - Merge replaces that entry's data and wstrb in place; count is unchanged.
  - A merging write is accepted even when full: in_wr_rdy = !full || merge_hit.
  - Uncached writes never merge.
- Undefined: every accepted write allocates a new entry.

Test Plan:
- Reset: assert resetn = 0 mid-ISSUE with count = 3 -> data_wr_req = 0 immediately; after release in_wr_rdy = 1, sched_empty = write_buffer_empty.
- Fill and drain: hold data_wr_rdy = 0 and push lines 0x100, 0x200, 0x300, 0x400 -> in_wr_rdy = 0 after the 4th and a 5th push stalls. Raise data_wr_rdy -> bridge sees 0x100, 0x200, 0x300, 0x400 in order with at least 3 cycles between reqs.
- Hazard: line 0x1000 queued and data_wr_rdy = 0; read type 3'b100 at 0x100C -> in_rd_rdy = 0, data_rd_req = 0; read at 0x2000 -> passes the same cycle. After 0x1000 is handed off -> the 0x100C read passes.
- Uncached read: type 3'b010 at 0xBFAF0000 with count = 1 -> blocked until the entry is issued and write_buffer_empty = 1, then passes.
- Merge with WRQ_MERGE_EN: 0x100 in ISSUE; push 0x300 (data A) then 0x300 (data B) -> count = 2 and the bridge sees 0x300 once with data B. Without the macro -> count = 3 and 0x300 is issued twice (A then B).
- Wrap: push/pop 10 entries with simultaneous push+pop at count = 2 -> order preserved, count stays 2 across the pointer wrap.

Source files
------------

// File: rtl/dcache_wr_sched_if.sv
// Signal bundle between the dcache, the write scheduler and the AXI bridge data-side cache port.
// slave is the scheduler's view; master is the view of whatever drives the dcache and bridge sides.
interface dcache_wr_sched_if;
  logic         in_wr_req;
  logic [2:0]   in_wr_type;
  logic [31:0]  in_wr_addr;
  logic [3:0]   in_wr_wstrb;
  logic [127:0] in_wr_data;
  logic         in_wr_rdy;
  logic         in_rd_req;
  logic [2:0]   in_rd_type;
  logic [31:0]  in_rd_addr;
  logic         in_rd_rdy;
  logic         data_wr_req;
  logic [2:0]   data_wr_type;
  logic [31:0]  data_wr_addr;
  logic [3:0]   data_wr_wstrb;
  logic [127:0] data_wr_data;
  logic         data_wr_rdy;
  logic         data_rd_req;
  logic [2:0]   data_rd_type;
  logic [31:0]  data_rd_addr;
  logic         data_rd_rdy;
  logic         write_buffer_empty;
  logic         sched_empty;

  modport slave (
    input  in_wr_req, in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data,
    output in_wr_rdy,
    input  in_rd_req, in_rd_type, in_rd_addr,
    output in_rd_rdy,
    output data_wr_req, data_wr_type, data_wr_addr, data_wr_wstrb, data_wr_data,
    input  data_wr_rdy,
    output data_rd_req, data_rd_type, data_rd_addr,
    input  data_rd_rdy,
    input  write_buffer_empty,
    output sched_empty
  );

  modport master (
    output in_wr_req, in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data,
    input  in_wr_rdy,
    output in_rd_req, in_rd_type, in_rd_addr,
    input  in_rd_rdy,
    input  data_wr_req, data_wr_type, data_wr_addr, data_wr_wstrb, data_wr_data,
    output data_wr_rdy,
    input  data_rd_req, data_rd_type, data_rd_addr,
    output data_rd_rdy,
    output write_buffer_empty,
    input  sched_empty
  );
endinterface

// File: rtl/dcache_wr_sched.sv
// FIFO write-queue scheduler feeding the bridge's single-entry write path; reads bypass unless hazarded.
// Optional macro WRQ_MERGE_EN: merge a full-line write into a queued entry for the same line.
module dcache_wr_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  dcache_wr_sched_if.slave bus
);
  localparam int         PTR_W = $clog2(DEPTH);
  localparam logic [2:0] LINE  = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state;

  logic [2:0]       q_type  [DEPTH];
  logic [31:0]      q_addr  [DEPTH];
  logic [3:0]       q_wstrb [DEPTH];
  logic [127:0]     q_data  [DEPTH];
  logic [PTR_W-1:0] offs    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic             full, push, pop, launch, merge_hit, rd_hit, block, empty_w;
  logic [3:0]       head_wstrb;
  logic [127:0]     head_data;

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]  = PTR_W'(i) - head;
      valid[i] = CNT_W'(offs[i]) < count;
    end
  end

  assign full   = (count == CNT_W'(DEPTH));
  assign launch = (state == IDLE) && (count != '0) && bus.data_wr_rdy;
  assign pop    = (state == ISSUE) && bus.data_wr_rdy;
  assign push   = bus.in_wr_req && bus.in_wr_rdy && !merge_hit;

`ifdef WRQ_MERGE_EN
  logic [PTR_W-1:0] merge_idx;

  // The head is only mergeable before it has been registered onto the bridge port.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    if (bus.in_wr_req && bus.in_wr_type == LINE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && q_type[i] == LINE && q_addr[i][31:4] == bus.in_wr_addr[31:4] &&
            (PTR_W'(i) != head || state == IDLE)) begin
          merge_hit = 1'b1;
          merge_idx = PTR_W'(i);
        end
      end
    end
  end

  assign bus.in_wr_rdy = !full || merge_hit;

  always_comb begin
    head_wstrb = q_wstrb[head];
    head_data  = q_data[head];
    if (merge_hit && merge_idx == head) begin
      head_wstrb = bus.in_wr_wstrb;
      head_data  = bus.in_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_type[tail]  <= bus.in_wr_type;
      q_addr[tail]  <= bus.in_wr_addr;
      q_wstrb[tail] <= bus.in_wr_wstrb;
      q_data[tail]  <= bus.in_wr_data;
    end
    if (merge_hit) begin
      q_wstrb[merge_idx] <= bus.in_wr_wstrb;
      q_data[merge_idx]  <= bus.in_wr_data;
    end
  end
`else
  assign merge_hit     = 1'b0;
  assign bus.in_wr_rdy = !full;
  assign head_wstrb    = q_wstrb[head];
  assign head_data     = q_data[head];

  always_ff @(posedge clk) begin
    if (push) begin
      q_type[tail]  <= bus.in_wr_type;
      q_addr[tail]  <= bus.in_wr_addr;
      q_wstrb[tail] <= bus.in_wr_wstrb;
      q_data[tail]  <= bus.in_wr_data;
    end
  end
`endif

  // Pointers, occupancy and the issue sequencer; GAP absorbs the bridge's rdy-deassert latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      state             <= IDLE;
      bus.data_wr_req   <= 1'b0;
      bus.data_wr_type  <= '0;
      bus.data_wr_addr  <= '0;
      bus.data_wr_wstrb <= '0;
      bus.data_wr_data  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (launch) begin
            state             <= ISSUE;
            bus.data_wr_req   <= 1'b1;
            bus.data_wr_type  <= q_type[head];
            bus.data_wr_addr  <= q_addr[head];
            bus.data_wr_wstrb <= head_wstrb;
            bus.data_wr_data  <= head_data;
          end
        end
        ISSUE: begin
          if (pop) begin
            state           <= GAP;
            bus.data_wr_req <= 1'b0;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Entries already handed to the bridge are gone from the queue, so the bridge orders them itself.
  always_comb begin
    rd_hit = push && (bus.in_wr_addr[31:4] == bus.in_rd_addr[31:4]);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && q_addr[i][31:4] == bus.in_rd_addr[31:4]) rd_hit = 1'b1;
    end
    rd_hit = rd_hit && bus.in_rd_req;
  end

  assign empty_w          = (count == '0) && (state == IDLE) && bus.write_buffer_empty;
  assign bus.sched_empty  = empty_w;
  assign block            = rd_hit || (bus.in_rd_type != LINE && !empty_w);
  assign bus.data_rd_req  = bus.in_rd_req && !block;
  assign bus.in_rd_rdy    = bus.data_rd_rdy && !block;
  assign bus.data_rd_type = bus.in_rd_type;
  assign bus.data_rd_addr = bus.in_rd_addr;
endmodule

// File: tb/tb_dcache_wr_sched.sv
// Directed bench for dcache_wr_sched: reset, fill/drain, read hazards, uncached hold, merge, pointer wrap.
// Merge expectations follow WRQ_MERGE_EN as defined for the build.
module tb_dcache_wr_sched;
`ifdef WRQ_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  int           total_checks = 0;
  int           bad_checks = 0;
  int           cycle = 0;
  logic [31:0]  iss_addr [$];
  logic [127:0] iss_data [$];
  int           iss_cycle [$];
  logic [31:0]  exp_addr [$];
  logic [127:0] exp_data [$];

  dcache_wr_sched_if bus ();

  dcache_wr_sched #(.DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Bridge-side monitor: records every accepted write handshake and the cycle it happened in.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (resetn && bus.data_wr_req && bus.data_wr_rdy) begin
      iss_addr.push_back(bus.data_wr_addr);
      iss_data.push_back(bus.data_wr_data);
      iss_cycle.push_back(cycle);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] line_data(input logic [31:0] a, input logic [7:0] tag);
    return {a, ~a, {24'h0, tag}, a ^ 32'hA5A5_0000};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [127:0] data);
    bus.in_wr_req   = wr;
    bus.in_wr_type  = 3'b100;
    bus.in_wr_addr  = addr;
    bus.in_wr_wstrb = 4'hF;
    bus.in_wr_data  = data;
  endtask

  task automatic push_line(input logic [31:0] addr, input logic [127:0] data);
    @(negedge clk);
    applyStimulus(1'b1, addr, data);
    #1 checkOutput("push_rdy", bus.in_wr_rdy, 1'b1);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 128'h0);
  endtask

  task automatic wait_issues(input int n, input int bound);
    int k = 0;
    while (iss_addr.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("issue_count", iss_addr.size(), n);
  endtask

  task automatic clear_log();
    iss_addr.delete();
    iss_data.delete();
    iss_cycle.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic compare_log(input string tag);
    for (int i = 0; i < exp_addr.size() && i < iss_addr.size(); i++) begin
      checkOutput({tag, "_addr"}, iss_addr[i], exp_addr[i]);
      checkOutput({tag, "_data"}, iss_data[i], exp_data[i]);
    end
  endtask

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 32'h0, 128'h0);
    bus.in_rd_req          = 1'b0;
    bus.in_rd_type         = 3'b100;
    bus.in_rd_addr         = 32'h0;
    bus.data_wr_rdy        = 1'b0;
    bus.data_rd_rdy        = 1'b1;
    bus.write_buffer_empty = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1 checkOutput("rst_wr_rdy", bus.in_wr_rdy, 1'b1);
    checkOutput("rst_wr_req", bus.data_wr_req, 1'b0);
    checkOutput("rst_sched_empty", bus.sched_empty, 1'b1);

    // Reset while the head is in ISSUE with three entries queued.
    for (int i = 1; i <= 3; i++) push_line(32'h100 * i, line_data(32'h100 * i, 8'h00));
    @(negedge clk);
    bus.data_wr_rdy = 1'b1;
    @(negedge clk);
    bus.data_wr_rdy = 1'b0;
    #1 checkOutput("pre_rst_req", bus.data_wr_req, 1'b1);
    checkOutput("pre_rst_addr", bus.data_wr_addr, 32'h100);
    @(negedge clk);
    resetn = 1'b0;
    #1 checkOutput("rst_drops_req", bus.data_wr_req, 1'b0);
    checkOutput("rst_clears_addr", bus.data_wr_addr, 32'h0);
    checkOutput("rst_clears_data", bus.data_wr_data, 128'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 checkOutput("post_rst_wr_rdy", bus.in_wr_rdy, 1'b1);
    checkOutput("post_rst_empty_wbe1", bus.sched_empty, 1'b1);
    bus.write_buffer_empty = 1'b0;
    #1 checkOutput("post_rst_empty_wbe0", bus.sched_empty, 1'b0);
    bus.write_buffer_empty = 1'b1;
    bus.data_wr_rdy = 1'b1;
    repeat (4) @(negedge clk);
    #1 checkOutput("post_rst_no_issue", bus.data_wr_req, 1'b0);
    checkOutput("post_rst_issue_cnt", iss_addr.size(), 0);
    bus.data_wr_rdy = 1'b0;

    // Fill to DEPTH, confirm the stall, then drain in order at the minimum spacing.
    clear_log();
    for (int i = 1; i <= 4; i++) begin
      push_line(32'h100 * i, line_data(32'h100 * i, 8'h11));
      exp_addr.push_back(32'h100 * i);
      exp_data.push_back(line_data(32'h100 * i, 8'h11));
    end
    @(negedge clk);
    applyStimulus(1'b1, 32'h500, line_data(32'h500, 8'h11));
    #1 checkOutput("full_wr_rdy", bus.in_wr_rdy, 1'b0);
    @(negedge clk);
    #1 checkOutput("full_stall", bus.in_wr_rdy, 1'b0);
    checkOutput("full_not_empty", bus.sched_empty, 1'b0);
    applyStimulus(1'b0, 32'h0, 128'h0);
    bus.data_wr_rdy = 1'b1;
    wait_issues(4, 40);
    compare_log("drain");
    for (int i = 1; i < iss_cycle.size(); i++) checkOutput("drain_spacing", iss_cycle[i] - iss_cycle[i-1], 3);
    checkOutput("drain_type", bus.data_wr_type, 3'b100);
    checkOutput("drain_wstrb", bus.data_wr_wstrb, 4'hF);
    repeat (3) @(negedge clk);
    #1 checkOutput("drain_empty", bus.sched_empty, 1'b1);
    checkOutput("drain_no_extra", iss_addr.size(), 4);
    bus.data_wr_rdy = 1'b0;

    // Read hazard against a queued line, bypass for a different line, release after hand-off.
    clear_log();
    push_line(32'h1000, line_data(32'h1000, 8'h22));
    @(negedge clk);
    bus.in_rd_req  = 1'b1;
    bus.in_rd_type = 3'b100;
    bus.in_rd_addr = 32'h100C;
    #1 checkOutput("hz_hit_rd_req", bus.data_rd_req, 1'b0);
    checkOutput("hz_hit_rd_rdy", bus.in_rd_rdy, 1'b0);
    bus.in_rd_addr = 32'h2000;
    #1 checkOutput("hz_bypass_req", bus.data_rd_req, 1'b1);
    checkOutput("hz_bypass_rdy", bus.in_rd_rdy, 1'b1);
    checkOutput("hz_bypass_addr", bus.data_rd_addr, 32'h2000);
    checkOutput("hz_bypass_type", bus.data_rd_type, 3'b100);
    bus.in_rd_addr = 32'h100C;
    @(negedge clk);
    bus.data_wr_rdy = 1'b1;
    @(negedge clk);
    #1 checkOutput("hz_issue_block", bus.data_rd_req, 1'b0);
    @(negedge clk);
    #1 checkOutput("hz_handoff_cnt", iss_addr.size(), 1);
    checkOutput("hz_after_handoff", bus.data_rd_req, 1'b1);
    checkOutput("hz_after_handoff_rdy", bus.in_rd_rdy, 1'b1);
    bus.data_wr_rdy = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'h3000, line_data(32'h3000, 8'h33));
    bus.in_rd_addr = 32'h3008;
    #1 checkOutput("hz_push_same_cycle", bus.data_rd_req, 1'b0);
    checkOutput("hz_push_same_rdy", bus.in_rd_rdy, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 128'h0);
    #1 checkOutput("hz_queued_block", bus.data_rd_req, 1'b0);
    bus.in_rd_req = 1'b0;
    bus.data_wr_rdy = 1'b1;
    wait_issues(2, 20);
    bus.data_wr_rdy = 1'b0;
    exp_addr = '{32'h1000, 32'h3000};
    exp_data = '{line_data(32'h1000, 8'h22), line_data(32'h3000, 8'h33)};
    compare_log("hz");

    // Uncached read waits for the queue, the FSM and the bridge write buffer to all be empty.
    clear_log();
    repeat (3) @(negedge clk);
    push_line(32'h5000, line_data(32'h5000, 8'h44));
    @(negedge clk);
    bus.in_rd_req  = 1'b1;
    bus.in_rd_type = 3'b010;
    bus.in_rd_addr = 32'hBFAF_0000;
    bus.write_buffer_empty = 1'b0;
    #1 checkOutput("uc_block_queued", bus.data_rd_req, 1'b0);
    checkOutput("uc_block_queued_rdy", bus.in_rd_rdy, 1'b0);
    bus.data_wr_rdy = 1'b1;
    wait_issues(1, 20);
    bus.data_wr_rdy = 1'b0;
    #1 checkOutput("uc_block_gap", bus.data_rd_req, 1'b0);
    repeat (3) @(negedge clk);
    #1 checkOutput("uc_block_wbe", bus.data_rd_req, 1'b0);
    bus.write_buffer_empty = 1'b1;
    #1 checkOutput("uc_pass_req", bus.data_rd_req, 1'b1);
    checkOutput("uc_pass_rdy", bus.in_rd_rdy, 1'b1);
    checkOutput("uc_pass_addr", bus.data_rd_addr, 32'hBFAF_0000);
    checkOutput("uc_pass_type", bus.data_rd_type, 3'b010);
    bus.data_rd_rdy = 1'b0;
    #1 checkOutput("uc_bridge_busy", bus.in_rd_rdy, 1'b0);
    bus.data_rd_rdy = 1'b1;
    bus.in_rd_req   = 1'b0;
    bus.in_rd_type  = 3'b100;

    // Two writes to 0x300 behind a head in ISSUE; a probe push exposes the resulting occupancy.
    clear_log();
    push_line(32'h100, line_data(32'h100, 8'h55));
    @(negedge clk);
    bus.data_wr_rdy = 1'b1;
    @(negedge clk);
    bus.data_wr_rdy = 1'b0;
    #1 checkOutput("mg_head_issue", bus.data_wr_req, 1'b1);
    push_line(32'h300, line_data(32'h300, 8'hAA));
    push_line(32'h300, line_data(32'h300, 8'hBB));
    push_line(32'h600, line_data(32'h600, 8'hCC));
    @(negedge clk);
    applyStimulus(1'b1, 32'h700, line_data(32'h700, 8'hDD));
    #1 checkOutput("mg_probe_rdy", bus.in_wr_rdy, MERGE_EN);
    checkOutput("mg_head_stable", bus.data_wr_addr, 32'h100);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 128'h0);
    exp_addr.push_back(32'h100);
    exp_data.push_back(line_data(32'h100, 8'h55));
`ifdef WRQ_MERGE_EN
    exp_addr.push_back(32'h300);
    exp_data.push_back(line_data(32'h300, 8'hBB));
    exp_addr.push_back(32'h600);
    exp_data.push_back(line_data(32'h600, 8'hCC));
    exp_addr.push_back(32'h700);
    exp_data.push_back(line_data(32'h700, 8'hDD));
`else
    exp_addr.push_back(32'h300);
    exp_data.push_back(line_data(32'h300, 8'hAA));
    exp_addr.push_back(32'h300);
    exp_data.push_back(line_data(32'h300, 8'hBB));
    exp_addr.push_back(32'h600);
    exp_data.push_back(line_data(32'h600, 8'hCC));
`endif
    bus.data_wr_rdy = 1'b1;
    wait_issues(4, 60);
    compare_log("mg");
    repeat (6) @(negedge clk);
    #1 checkOutput("mg_no_extra", iss_addr.size(), 4);
    checkOutput("mg_empty", bus.sched_empty, 1'b1);
    bus.data_wr_rdy = 1'b0;

    // Ten entries through four slots, pushing exactly on each pop so occupancy holds at two.
    clear_log();
    begin
      int n_pushed = 2;
      int guard = 0;
      for (int i = 0; i < 10; i++) begin
        exp_addr.push_back(32'h1_0000 + 32'h10 * i);
        exp_data.push_back(line_data(32'h1_0000 + 32'h10 * i, 8'(i)));
      end
      push_line(exp_addr[0], exp_data[0]);
      push_line(exp_addr[1], exp_data[1]);
      bus.data_wr_rdy = 1'b1;
      while (n_pushed < 10 && guard < 200) begin
        @(negedge clk);
        #1;
        if (bus.data_wr_req) begin
          applyStimulus(1'b1, exp_addr[n_pushed], exp_data[n_pushed]);
          #1 checkOutput("wrap_push_rdy", bus.in_wr_rdy, 1'b1);
          n_pushed++;
          @(posedge clk);
          #1 applyStimulus(1'b0, 32'h0, 128'h0);
        end
        guard++;
      end
      checkOutput("wrap_pushed", n_pushed, 10);
    end
    wait_issues(10, 100);
    compare_log("wrap");
    repeat (6) @(negedge clk);
    #1 checkOutput("wrap_no_extra", iss_addr.size(), 10);
    checkOutput("wrap_empty", bus.sched_empty, 1'b1);
    bus.data_wr_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end
endmodule
